// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls a burst of words from an upstream FIFO into a
// 2-entry output buffer, forwards them downstream with valid/ready and keeps
// a running modulo-2^32 sum of the words handed out.
module fifo_burst_reader (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_len,
  input  logic        i_abort,
  input  logic [3:0]  i_fifo_data_count,
  input  logic [31:0] i_fifo_dout,
  output logic        o_fifo_rd_en,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_sum,
  output logic [3:0]  o_words_left
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_words_left;
  logic [31:0] r_sum;
  logic [31:0] r_buf0;
  logic [31:0] r_buf1;
  logic [1:0]  r_cnt;
  logic        r_inflight;

  logic        w_active;
  logic        w_xfer;
  logic        w_cap;
  logic [2:0]  w_occ;
  logic        w_pop;
  logic [1:0]  w_slot;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] w_buf0_nxt;
  logic [31:0] w_buf1_nxt;

  // Handshake, capture and pop decisions for the current cycle.
  always_comb begin
    w_active = 1'b0;
    w_xfer   = 1'b0;
    w_cap    = 1'b0;
    w_occ    = 3'd0;
    w_pop    = 1'b0;
    if ((r_state == ST_RUN) || (r_state == ST_FLUSH)) begin
      w_active = 1'b1;
    end else begin
      w_active = 1'b0;
    end
    // The buffer is only ever non-empty while active, so valid is just occupancy.
    w_xfer = (r_cnt != 2'd0) && i_out_ready;
    w_cap  = w_active && r_inflight && !i_abort;
    // A word leaving this cycle frees its slot, which lets pops run back to
    // back while downstream keeps up; occupancy after the edge never exceeds 2.
    w_occ  = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
    w_pop  = (r_state == ST_RUN) && !i_abort && (r_words_left != 4'd0) &&
             (i_fifo_data_count != 4'd0) && (w_occ < 3'd2);
  end

  // Next contents of the ordered 2-entry buffer (shift on transfer, fill tail on capture).
  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    w_slot     = r_cnt - {1'b0, w_xfer};
    w_cnt_nxt  = r_cnt + {1'b0, w_cap} - {1'b0, w_xfer};
    if (w_xfer) begin
      w_buf0_nxt = r_buf1;
    end else begin
      w_buf0_nxt = r_buf0;
    end
    if (w_cap) begin
      if (w_slot == 2'd0) begin
        w_buf0_nxt = i_fifo_dout;
      end else begin
        w_buf1_nxt = i_fifo_dout;
      end
    end else begin
      w_buf1_nxt = r_buf1;
    end
  end

  // Burst sequencing: IDLE -> RUN -> FLUSH -> DONE -> IDLE, abort short-cuts to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len == 4'd0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_DONE;
        end else if (w_pop && (r_words_left == 4'd1)) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (i_abort) begin
          w_state_nxt = ST_DONE;
        end else if ((r_cnt == 2'd0) && !r_inflight) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters, sum and buffer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_words_left <= 4'd0;
      r_sum        <= 32'd0;
      r_buf0       <= 32'd0;
      r_buf1       <= 32'd0;
      r_cnt        <= 2'd0;
      r_inflight   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && i_start) begin
        r_words_left <= i_len;
        r_sum        <= 32'd0;
        r_buf0       <= 32'd0;
        r_buf1       <= 32'd0;
        r_cnt        <= 2'd0;
        r_inflight   <= 1'b0;
      end else if (w_active && i_abort) begin
        // A handshake in the abort cycle still counts; everything pending is dropped.
        if (w_xfer) begin
          r_sum <= r_sum + r_buf0;
        end
        r_buf0     <= 32'd0;
        r_buf1     <= 32'd0;
        r_cnt      <= 2'd0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_pop;
        if (w_pop) begin
          r_words_left <= r_words_left - 4'd1;
        end
        if (w_xfer) begin
          r_sum <= r_sum + r_buf0;
        end
        r_cnt  <= w_cnt_nxt;
        r_buf0 <= w_buf0_nxt;
        r_buf1 <= w_buf1_nxt;
      end
    end
  end

  assign o_fifo_rd_en = w_pop;
  assign o_out_valid  = (r_cnt != 2'd0);
  assign o_out_data   = r_buf0;
  assign o_busy       = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign o_done       = (r_state == ST_DONE);
  assign o_sum        = r_sum;
  assign o_words_left = r_words_left;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: upstream FIFO model, output scoreboard,
// a table of complete bursts and hand-written corner-case sequences.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [3:0]  len;
  logic [3:0]  fifo_cnt = 4'd0;
  logic [31:0] fifo_dout = 32'd0;
  logic        rd_en, out_valid, busy, done;
  logic [31:0] out_data, sum;
  logic [3:0]  words_left;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int pop_cyc[$];
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]        len;
    int                nwords;
    logic [3:0][31:0]  d;
    bit                toggle;
    logic [31:0]       exp_sum;
    int                exp_pops;
    int                span;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len), .i_abort(abort),
    .i_fifo_data_count(fifo_cnt), .i_fifo_dout(fifo_dout), .o_fifo_rd_en(rd_en),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_words_left(words_left)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Upstream FIFO: data appears the cycle after a pop, count is registered.
  always @(posedge clk) begin
    if (rd_en && (mq.size() > 0)) fifo_dout <= mq.pop_front();
    fifo_cnt <= (mq.size() > 8) ? 4'd8 : 4'(mq.size());
  end

  // Monitor away from the active edge: pop legality, scoreboard, done pulses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (rd_en) begin
        chk("rd_en_with_count", {31'd0, fifo_cnt != 4'd0}, 32'd1);
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got 0x%08h want no word", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    pop_cnt = 0;
    done_cnt = 0;
    pop_cyc.delete();
  endtask

  task automatic preload(input logic [31:0] w, input bit expect_out);
    mq.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic start_burst(input logic [3:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
    len = 4'd0;
  endtask

  task automatic wait_done(input string nm, input bit toggle);
    int n = 0;
    while ((done_cnt == 0) && (n < 200)) begin
      if (toggle) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done want done within 200 cycles", nm);
    end
    out_ready = 1'b1;
  endtask

  task automatic cleanup();
    mq.delete();
    exp_q.delete();
    step();
    step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_out_data"}, out_data, 32'd0);
    chk({nm, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_sum"}, sum, 32'd0);
    chk({nm, "_words_left"}, {28'd0, words_left}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'd3, 3, {32'h0, 32'h3, 32'h2, 32'h1}, 1'b0, 32'h6, 3, 2};
    vecs[1] = '{4'd4, 4, {32'h28, 32'h1E, 32'h14, 32'hA}, 1'b1, 32'h64, 4, -1};
    vecs[2] = '{4'd2, 2, {32'h0, 32'h0, 32'h2, 32'hFFFFFFFF}, 1'b0, 32'h1, 2, 1};
    vecs[3] = '{4'd1, 2, {32'h0, 32'h0, 32'h5, 32'hDEADBEEF}, 1'b0, 32'hDEADBEEF, 1, 0};
    vecs[4] = '{4'd4, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                1'b1, 32'hAAAAAAAA, 4, -1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; len = 4'd0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Table of complete bursts.
    for (int i = 0; i < 5; i++) begin
      clear_stats();
      for (int k = 0; k < vecs[i].nwords; k++) preload(vecs[i].d[k], k < int'(vecs[i].len));
      step();
      step();
      out_ready = 1'b1;
      start_burst(vecs[i].len);
      wait_done($sformatf("vec%0d", i), vecs[i].toggle);
      chk($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      chk($sformatf("vec%0d_pops", i), 32'(pop_cnt), 32'(vecs[i].exp_pops));
      chk($sformatf("vec%0d_done_pulses", i), 32'(done_cnt), 32'd1);
      chk($sformatf("vec%0d_words_out", i), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_words_left", i), {28'd0, words_left}, 32'd0);
      if ((vecs[i].span >= 0) && (pop_cyc.size() > 0))
        chk($sformatf("vec%0d_pop_span", i), 32'(pop_cyc[pop_cyc.size() - 1] - pop_cyc[0]),
            32'(vecs[i].span));
      cleanup();
    end

    // Downstream back-pressure: only two words may be fetched.
    clear_stats();
    preload(32'h5, 1'b1); preload(32'h6, 1'b1); preload(32'h7, 1'b1); preload(32'h8, 1'b1);
    step(); step();
    out_ready = 1'b0;
    start_burst(4'd4);
    repeat (10) step();
    chk("bp_pops", 32'(pop_cnt), 32'd2);
    chk("bp_rd_en", {31'd0, rd_en}, 32'd0);
    chk("bp_out_data_held", out_data, 32'h5);
    out_ready = 1'b1;
    wait_done("bp", 1'b0);
    chk("bp_pops_total", 32'(pop_cnt), 32'd4);
    chk("bp_sum", sum, 32'h1A);
    chk("bp_words_out", 32'(exp_q.size()), 32'd0);
    cleanup();

    // Empty FIFO stalls; a start while busy is ignored.
    clear_stats();
    start_burst(4'd2);
    repeat (5) step();
    chk("stall_pops", 32'(pop_cnt), 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    start_burst(4'd5);
    chk("stall_start_ignored", {28'd0, words_left}, 32'd2);
    preload(32'hA, 1'b1); preload(32'hB, 1'b1);
    wait_done("stall", 1'b0);
    chk("stall_sum", sum, 32'h15);
    chk("stall_pops_total", 32'(pop_cnt), 32'd2);
    chk("stall_done_pulses", 32'(done_cnt), 32'd1);
    cleanup();

    // Zero-length burst.
    clear_stats();
    start_burst(4'd0);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    step();
    chk("len0_done_low", {31'd0, done}, 32'd0);
    chk("len0_sum", sum, 32'd0);
    chk("len0_pops", 32'(pop_cnt), 32'd0);
    chk("len0_done_pulses", 32'(done_cnt), 32'd1);
    cleanup();

    // Abort in RUN with three words still to request.
    clear_stats();
    preload(32'h100, 1'b1); preload(32'h200, 1'b1); preload(32'h300, 1'b0);
    step(); step();
    out_ready = 1'b0;
    start_burst(4'd5);
    repeat (5) step();
    chk("abort_pre_words_left", {28'd0, words_left}, 32'd3);
    chk("abort_pre_valid", {31'd0, out_valid}, 32'd1);
    abort = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
    step();
    abort = 1'b0;
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_words_left", {28'd0, words_left}, 32'd3);
    chk("abort_sum", sum, 32'h100);
    step();
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_idle_done", {31'd0, done}, 32'd0);
    chk("abort_in_idle_busy", {31'd0, busy}, 32'd0);
    cleanup();

    // Reset in the middle of a burst.
    clear_stats();
    preload(32'hFFFFFFFF, 1'b1); preload(32'h2, 1'b1);
    step(); step();
    out_ready = 1'b1;
    start_burst(4'd2);
    step();
    step();
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    repeat (4) step();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    cleanup();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
